data_mem_responder: RTL and testbench

- Word-organised data memory that sits on the load/store side of the single-cycle core's data port.
- Accepts one read or write request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a response through a valid/ready handshake.
- Lets the core and its benches run with a realistic, stallable memory instead of a zero-latency array.

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Word-organised data memory for the load/store side of the core.
//             Accepts one request at a time over a valid/ready handshake,
//             spends a fixed number of wait cycles on it, then returns a
//             response over a second valid/ready handshake.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             req_valid/req_ready            - request handshake
//             req_we, req_addr, req_wdata,
//             req_be                         - request payload
//             rsp_valid/rsp_ready            - response handshake
//             rsp_rdata, rsp_err             - response payload
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);
    // One past the last valid byte, held in 33 bits so a window touching the
    // top of the address space does not wrap around to accept low addresses.
    localparam logic [32:0] c_END_ADDR  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_rsp_valid;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                w_commit;
    logic                w_accept;
    logic                w_err;
    logic [c_IDX_W-1:0]  w_idx;

    logic [31:0]         r_mem [DEPTH_WORDS];

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept  = req_valid && (r_state == ST_IDLE);

    // Address decode works on the latched request only.
    assign w_err = (r_addr[1:0] != 2'b00)
                || (r_addr < BASE_ADDR)
                || ({1'b0, r_addr} >= c_END_ADDR);
    assign w_idx = c_IDX_W'((r_addr - BASE_ADDR) >> 2);

    // Every request spends WAIT_STATES+1 cycles in WAIT: the counter counts the
    // configured wait states and the final cycle (counter at zero) is the
    // memory access itself, committed on the edge that enters RESP. This puts
    // rsp_valid high after edge T+1+WAIT_STATES for a request accepted at T.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Payload is only captured on acceptance, so junk on req_* while
            // req_valid is low never reaches the state.
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= c_WAIT_INIT;
            end

            if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_err       <= w_err;
                r_rdata     <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rdata     <= 32'd0;
                r_err       <= 1'b0;
            end
        end
    end

    // Storage is never reset. The rst guard keeps a store that is interrupted
    // on its commit edge from landing in the array.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. A transaction-level
//             model predicts handshake timing, memory contents and responses;
//             directed sequences pin the model with literal expectations and
//             a randomized phase exercises mixed traffic, backpressure and
//             resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          c_DEPTH = 256;
    localparam logic [31:0] c_BASE  = 32'h0000_0000;
    localparam int          c_WS    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b1;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    data_mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .BASE_ADDR   (c_BASE),
        .WAIT_STATES (c_WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] m_mem [c_DEPTH];
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_due  = 0;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    bit          m_err;

    function automatic bit addr_bad(input logic [31:0] a);
        longint la = longint'(a);
        return (la % 4 != 0) || (la < longint'(c_BASE)) ||
               (la >= longint'(c_BASE) + 4 * c_DEPTH);
    endfunction

    always @(negedge clk) begin
        bit exp_rv;
        int idx;
        logic [31:0] mask;
        if (m_live) begin
            exp_rv = m_busy && m_done;
            chk("model req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("model rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
            chk("model rsp_rdata", rsp_rdata, exp_rv ? m_rdata : 32'd0);
            chk("model rsp_err", {31'd0, rsp_err}, {31'd0, exp_rv && m_err});
        end
        // Predict what the coming rising edge does.
        if (rst) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy  = 1'b1;
                    m_done  = 1'b0;
                    m_we    = req_we;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_be    = req_be;
                    // accept edge is cyc+1; response visible after edge accept+1+WS
                    m_due   = cyc + 2 + c_WS;
                end
            end else if (!m_done) begin
                if (cyc + 1 == m_due) begin
                    m_done  = 1'b1;
                    m_err   = addr_bad(m_addr);
                    m_rdata = 32'd0;
                    if (!m_err) begin
                        idx = int'((m_addr - c_BASE) / 4);
                        if (m_we) begin
                            mask = {{8{m_be[3]}}, {8{m_be[2]}}, {8{m_be[1]}}, {8{m_be[0]}}};
                            m_mem[idx] = (m_mem[idx] & ~mask) | (m_wdata & mask);
                        end else begin
                            m_rdata = m_mem[idx];
                        end
                    end
                end
            end else if (rsp_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+#1) ----------------
    task automatic junk_req();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int acc_edge);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!got && n < 200) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            n++;
        end
        #1;
        acc_edge = cyc;
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL accept timeout: got no req_ready expected accept within 200 cycles");
        end
        junk_req();
    endtask

    task automatic get_rsp(input int acc_edge, output logic [31:0] rdata,
                           output logic err, output int lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        rdata = 32'hx;
        err   = 1'bx;
        lat   = -1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rsp_valid) begin
                got   = 1'b1;
                rdata = rsp_rdata;
                err   = rsp_err;
                lat   = cyc - acc_edge;
            end
            n++;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL response timeout: got no rsp_valid expected one within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata,
                        output logic err, output int lat);
        int acc;
        send(we, addr, wdata, be, acc);
        get_rsp(acc, rdata, err, lat);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = (32'h40 + 32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(1, 3));
            1:       a = 32'h400 + 32'($urandom_range(0, 15)) * 4;
            2:       a = 32'hFFFF_FFFC;
            default: a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
        endcase
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;

        // Reset with a request pending: nothing may be accepted.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        junk_req();
        @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;

        // Fill every word so the model knows the whole array.
        for (int i = 0; i < c_DEPTH; i++) begin
            xfer(1'b1, c_BASE + 32'(i) * 4, $urandom, 4'hF, rd, er, lat);
        end

        // Full-word store then load with latency checks.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("store latency", 32'(lat), 32'd2);
        chk("store err", {31'd0, er}, 32'd0);
        chk("store rdata", rd, 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("load latency", 32'(lat), 32'd2);
        chk("load rdata", rd, 32'hDEADBEEF);
        chk("load err", {31'd0, er}, 32'd0);

        // Byte lanes.
        xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("byte lane merge", rd, 32'h11BB33DD);
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be=0 store err", {31'd0, er}, 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        chk("be=0 no change", rd, 32'h11BB33DD);

        // Errors.
        xfer(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        chk("misaligned err", {31'd0, er}, 32'd1);
        chk("misaligned rdata", rd, 32'd0);
        xfer(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
        chk("range err", {31'd0, er}, 32'd1);
        chk("range rdata", rd, 32'd0);
        xfer(1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
        xfer(1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, rd, er, lat);
        xfer(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        chk("oob store err", {31'd0, er}, 32'd1);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        chk("word0 intact", rd, 32'h01020304);
        xfer(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
        chk("word255 intact", rd, 32'hA5A5_5A5A);
        xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, rd, er, lat);
        chk("top addr err", {31'd0, er}, 32'd1);

        // Backpressure.
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'hF, acc);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 50);
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp after req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp after rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a store.
        xfer(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
        send(1'b1, 32'h30, 32'h12345678, 4'hF, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midreset no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
        chk("midreset store dropped", rd, 32'h0);

        // Randomized traffic with random backpressure and occasional resets.
        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            send(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom), acc);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1 junk_req();
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
